// File: rtl/mnist_pixel_buffer.sv
// Ping-pong 28x28 binary frame store: random-access pixel writes into one bank,
// valid/ready streaming of the other bank once a frame has been committed.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | no frame streaming; a commit is accepted immediately
// S_STREAM | read bank streaming pixel 0..NPIX-1; commits dropped unless
//          | they coincide with the final beat transfer
module mnist_pixel_buffer #(
  parameter int NPIX = 784,
  parameter int AW   = 10
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic          wr_data_i,
  input  logic          wr_en_i,
  output logic          pix_data_o,
  output logic          pix_valid_o,
  input  logic          pix_ready_i,
  output logic          pix_last_o,
  output logic [AW-1:0] pix_idx_o,
  output logic          frame_ready_o,
  output logic          busy_o,
  output logic [7:0]    drop_count_o
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);

  typedef enum logic {
    S_IDLE,
    S_STREAM
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          wr_bank_q, wr_bank_d;
  logic [7:0]    drop_q, drop_d;
  logic          frame_ready_q, frame_ready_d;

  logic [NPIX-1:0] mem_q [2];

  logic rd_bank;
  logic wr_ok;
  logic commit;
  logic xfer;
  logic last_xfer;

  // The read bank is always the complement of the write bank, so the two
  // can never coincide.
  assign rd_bank   = ~wr_bank_q;
  assign wr_ok     = wr_en_i && (wr_addr_i <= LAST_ADDR);
  assign commit    = wr_en_i && (wr_addr_i == LAST_ADDR);
  assign xfer      = (state_q == S_STREAM) && pix_ready_i;
  assign last_xfer = xfer && (idx_q == LAST_ADDR);

  always_ff @(posedge clk_i) begin
    if (wr_ok) begin
      mem_q[wr_bank_q][wr_addr_i] <= wr_data_i;
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    wr_bank_d     = wr_bank_q;
    drop_d        = drop_q;
    frame_ready_d = 1'b0;

    if (xfer) begin
      if (idx_q == LAST_ADDR) begin
        state_d = S_IDLE;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end

    // An accepted commit overrides the end-of-frame return to idle.
    if (commit) begin
      if (state_q == S_IDLE || last_xfer) begin
        state_d       = S_STREAM;
        idx_d         = '0;
        wr_bank_d     = ~wr_bank_q;
        frame_ready_d = 1'b1;
      end else if (drop_q != 8'hFF) begin
        drop_d = drop_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      wr_bank_q     <= 1'b0;
      drop_q        <= 8'd0;
      frame_ready_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      wr_bank_q     <= wr_bank_d;
      drop_q        <= drop_d;
      frame_ready_q <= frame_ready_d;
    end
  end

  assign busy_o        = (state_q == S_STREAM);
  assign pix_valid_o   = busy_o;
  assign pix_idx_o     = idx_q;
  assign pix_last_o    = pix_valid_o && (idx_q == LAST_ADDR);
  assign pix_data_o    = pix_valid_o ? mem_q[rd_bank][idx_q] : 1'b0;
  assign frame_ready_o = frame_ready_q;
  assign drop_count_o  = drop_q;

endmodule

// File: tb/tb_mnist_pixel_buffer.sv
// Scoreboard bench for mnist_pixel_buffer: directed frames push expected beats,
// a forked monitor pops and compares every transferred beat.
module tb_mnist_pixel_buffer;
  localparam int NPIX = 784;
  localparam int AW   = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] wr_addr;
  logic          wr_data;
  logic          wr_en;
  logic          pix_data;
  logic          pix_valid;
  logic          pix_ready;
  logic          pix_last;
  logic [AW-1:0] pix_idx;
  logic          frame_ready;
  logic          busy;
  logic [7:0]    drop_count;

  mnist_pixel_buffer #(.NPIX(NPIX), .AW(AW)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .wr_addr_i    (wr_addr),
    .wr_data_i    (wr_data),
    .wr_en_i      (wr_en),
    .pix_data_o   (pix_data),
    .pix_valid_o  (pix_valid),
    .pix_ready_i  (pix_ready),
    .pix_last_o   (pix_last),
    .pix_idx_o    (pix_idx),
    .frame_ready_o(frame_ready),
    .busy_o       (busy),
    .drop_count_o (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          d;
    logic [AW-1:0] idx;
    logic          last;
  } beat_t;

  beat_t exp_q[$];
  int    checks  = 0;
  int    errors  = 0;
  int    fr_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, req);
    end
  endtask

  function automatic logic pat(input int mode, input int a);
    case (mode)
      0: return (a < 392);
      1: return 1'b1;
      2: return 1'b0;
      3: return (a % 3) == 0;
      4: return a[0];
      5: return (a % 7) < 3;
      6: return a[1] ^ a[4];
      default: return (a % 11) == 0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic d);
    wr_en   = 1'b1;
    wr_addr = a[AW-1:0];
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic write_body(input int mode);
    for (int a = 0; a < NPIX - 1; a++) wr(a, pat(mode, a));
  endtask

  task automatic commit(input int mode);
    wr(NPIX - 1, pat(mode, NPIX - 1));
  endtask

  task automatic push_frame(input int mode);
    beat_t b;
    for (int a = 0; a < NPIX; a++) begin
      b.d    = pat(mode, a);
      b.idx  = a[AW-1:0];
      b.last = (a == NPIX - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || pix_valid) && n < budget) begin
      step();
      n++;
    end
    chk("drain_complete", {31'd0, (exp_q.size() == 0 && !pix_valid)}, 32'd1);
  endtask

  task automatic monitor();
    logic          stall = 1'b0;
    logic          h_d = 1'b0;
    logic          h_last = 1'b0;
    logic [AW-1:0] h_idx = '0;
    beat_t         e;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall = 1'b0;
        continue;
      end
      if (stall && pix_valid) begin
        chk("stall_data_stable", {31'd0, pix_data}, {31'd0, h_d});
        chk("stall_idx_stable", {22'd0, pix_idx}, {22'd0, h_idx});
        chk("stall_last_stable", {31'd0, pix_last}, {31'd0, h_last});
      end
      if (pix_valid && pix_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat_idx", {22'd0, pix_idx}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", {31'd0, pix_data}, {31'd0, e.d});
          chk("beat_idx", {22'd0, pix_idx}, {22'd0, e.idx});
          chk("beat_last", {31'd0, pix_last}, {31'd0, e.last});
        end
      end
      if (frame_ready) fr_seen++;
      stall  = pix_valid && !pix_ready;
      h_d    = pix_data;
      h_idx  = pix_idx;
      h_last = pix_last;
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout actual running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int cyc;
    rst       = 1'b1;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = 1'b0;
    pix_ready = 1'b0;
    fork
      monitor();
    join_none
    repeat (3) step();
    rst = 1'b0;

    chk("rst_valid", {31'd0, pix_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_frame_ready", {31'd0, frame_ready}, 32'd0);
    chk("rst_last", {31'd0, pix_last}, 32'd0);
    chk("rst_data", {31'd0, pix_data}, 32'd0);
    chk("rst_idx", {22'd0, pix_idx}, 32'd0);
    chk("rst_drop", {24'd0, drop_count}, 32'd0);

    // basic frame
    pix_ready = 1'b1;
    write_body(0);
    push_frame(0);
    commit(0);
    chk("basic_frame_ready", {31'd0, frame_ready}, 32'd1);
    chk("basic_valid", {31'd0, pix_valid}, 32'd1);
    chk("basic_idx0", {22'd0, pix_idx}, 32'd0);
    drain(2000);
    chk("basic_frames", fr_seen, 32'd1);
    chk("basic_drop", {24'd0, drop_count}, 32'd0);

    // backpressure with alternating ready
    write_body(3);
    push_frame(3);
    commit(3);
    cyc = 0;
    while (pix_valid && cyc < 4000) begin
      cyc++;
      step();
      pix_ready = ~pix_ready;
    end
    pix_ready = 1'b1;
    chk("bp_cycles_in_range", {31'd0, (cyc >= 1567 && cyc <= 1568)}, 32'd1);
    chk("bp_queue_empty", exp_q.size(), 32'd0);
    chk("bp_frames", fr_seen, 32'd2);

    // drop: frame B completes while A is stalled
    pix_ready = 1'b0;
    write_body(1);
    push_frame(1);
    commit(1);
    write_body(2);
    commit(2);
    step();
    chk("drop_count_one", {24'd0, drop_count}, 32'd1);
    chk("drop_frames", fr_seen, 32'd3);
    chk("drop_busy", {31'd0, busy}, 32'd1);
    pix_ready = 1'b1;
    drain(2000);
    chk("drop_count_after", {24'd0, drop_count}, 32'd1);
    chk("drop_frames_after", fr_seen, 32'd3);

    // reset mid-stream at beat 100
    write_body(4);
    push_frame(4);
    commit(4);
    n = 0;
    while (pix_idx != 10'd100 && n < 300) begin
      step();
      n++;
    end
    chk("mid_reached_100", {22'd0, pix_idx}, 32'd100);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_valid", {31'd0, pix_valid}, 32'd0);
    chk("mid_idx", {22'd0, pix_idx}, 32'd0);
    chk("mid_drop", {24'd0, drop_count}, 32'd0);
    chk("mid_busy", {31'd0, busy}, 32'd0);
    exp_q.delete();
    repeat (20) step();
    chk("mid_no_resume", {31'd0, pix_valid}, 32'd0);
    chk("mid_frames", fr_seen, 32'd4);

    // back-to-back: B commit lands on A's final transfer
    write_body(5);
    push_frame(5);
    commit(5);
    for (int a = 0; a < NPIX - 1; a++) wr(a, pat(6, a));
    chk("b2b_a_last_pending", {31'd0, pix_last}, 32'd1);
    push_frame(6);
    commit(6);
    chk("b2b_frame_ready", {31'd0, frame_ready}, 32'd1);
    chk("b2b_valid_no_gap", {31'd0, pix_valid}, 32'd1);
    chk("b2b_idx0", {22'd0, pix_idx}, 32'd0);
    chk("b2b_drop", {24'd0, drop_count}, 32'd0);
    drain(2000);
    chk("b2b_frames", fr_seen, 32'd6);

    // out-of-range writes neither commit nor corrupt
    write_body(7);
    wr(784, 1'b1);
    wr(900, 1'b1);
    wr(1023, 1'b1);
    repeat (3) step();
    chk("oor_no_frame", fr_seen, 32'd6);
    chk("oor_idle", {31'd0, pix_valid}, 32'd0);
    push_frame(7);
    commit(7);
    chk("oor_commit_ready", {31'd0, frame_ready}, 32'd1);
    drain(2000);
    chk("oor_frames", fr_seen, 32'd7);
    chk("oor_drop", {24'd0, drop_count}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
